sdram_arbiter: RTL and testbench
================================

// Module: sdram_arbiter
// PURPOSE
//  Two-port arbiter in front of the SDRAM controller's req/ack/valid/q interface.
//  Port 0 (instruction fetch) and port 1 (data access) each see a private copy of that interface.
//  One transaction is in flight at a time: arbitration, then forward to the controller, then route ack/valid/q back.
//  Sits between the core bus adapters and the SDRAM controller; exposes dbg_state for on-board probing.
// PARAMETERS
//  ADDR_W  24  word address width
//  DATA_W  32  data width; BWE_W = DATA_W/8 byte enables
//  RR      1   1: round-robin priority; 0: fixed priority, port 0 always wins
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  reset_n      in   1        asynchronous, active-low reset
//  pN_addr      in   ADDR_W   port N address (N = 0, 1)
//  pN_data      in   DATA_W   port N write data
//  pN_bwe       in   BWE_W    port N byte enables
//  pN_we        in   1        port N write (1) / read (0)
//  pN_req       in   1        port N request; held high until pN_ack
//  pN_ack       out  1        port N request accepted (1-cycle pulse)
//  pN_valid     out  1        port N read data valid (1-cycle pulse)
//  pN_q         out  DATA_W   port N read data; meaningful only while pN_valid is high
//  mem_addr/data/bwe/we/req   out  ADDR_W/DATA_W/BWE_W/1/1   to the SDRAM controller
//  mem_ack, mem_valid         in   1   from the SDRAM controller
//  mem_q        in   DATA_W   SDRAM read data
//  dbg_state    out  2        current FSM state encoding
// BEHAVIOUR
//  Reset (reset_n=0, asynchronous): state=IDLE, grant=0, last=1 (port 0 wins first).
//   All outputs are 0 during reset and immediately after release.
//  FSM states: IDLE=0, GRANT=1, WAIT_RD=2. Encoding 3 is illegal and returns to IDLE next cycle.
//  IDLE: mem_req=0, mem_* buses driven to 0.
//   If any pN_req is high, register grant and go to GRANT.
//   RR=1, both requesting: grant=~last. RR=0, both requesting: grant=0.
//   One requester only: that port. No request: stay in IDLE.
//  GRANT: mem_addr/data/bwe/we/req = granted port's inputs (mux on registered grant).
//   pG_ack = mem_ack (combinational); the other port's ack and valid stay 0.
//   mem_ack && we: last<=grant, go to IDLE.
//   mem_ack && !we: latch nothing, go to WAIT_RD.
//   Granted pG_req drops before ack (protocol violation): abort and go to IDLE; last unchanged.
//  WAIT_RD: mem_req=0, mem_* buses 0.
//   pG_valid = mem_valid (combinational); pN_q = mem_q on both ports.
//   On mem_valid: last<=grant, go to IDLE.
//   New pN_req is ignored until IDLE; the earliest next grant is 1 cycle after the IDLE re-entry.
//  Latency: 1 cycle from pN_req to mem_req (IDLE->GRANT). Ack and valid add zero cycles.
//   Back-to-back transactions have 1 idle cycle between them.
//  mem_valid in IDLE or GRANT: ignored, not routed to either port.
//  Reset asserted mid-transaction: immediate return to IDLE, mem_req=0. Outstanding valid is discarded.
//  dbg_state = state.
// TESTING
//  1. p0 write addr=0x000000 data=0, bwe=F, mem_ack after 3 cycles
//     -> mem_req rises 1 cycle after p0_req; p0_ack is 1 pulse; p1_ack stays 0.
//  2. p1 read addr=0x40CAFE, mem_valid with mem_q=0xFEEDBEEF
//     -> p1_valid pulses with p1_q=0xFEEDBEEF; p0_valid stays 0.
//  3. RR=1, p0 and p1 request reads continuously
//     -> grants alternate 0,1,0,1; each port serves 1 transaction per 2.
//  4. RR=0, both request continuously -> only port 0 is granted; port 1 starves until p0_req=0.
//  5. reset_n pulled low in WAIT_RD, then late mem_valid
//     -> all outputs 0, dbg_state=0; no pN_valid pulse.
//  6. p1_req dropped in GRANT before mem_ack -> mem_req falls the same cycle; IDLE next cycle; no p1_ack.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter_if
// Purpose  : One copy of the SDRAM request/ack/valid/q bus. It is used for
//            each requesting port and for the link to the SDRAM controller.
// Signals  : addr, data, bwe, we, req  - driven by the requester
//            ack, valid, q             - driven by the responder
// Modports : master - the requester side (drives the request fields)
//            slave  - the responder side (drives ack/valid/q)
// Revision : 1.0 - initial release
// ============================================================================
interface sdram_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  localparam int BWE_W = DATA_W / 8;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [BWE_W-1:0]  bwe;
  logic              we;
  logic              req;
  logic              ack;
  logic              valid;
  logic [DATA_W-1:0] q;

  modport master (
    output addr, data, bwe, we, req,
    input  ack, valid, q
  );

  modport slave (
    input  addr, data, bwe, we, req,
    output ack, valid, q
  );
endinterface
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Purpose  : Two-port arbiter in front of the SDRAM controller. Port 0 is
//            instruction fetch and port 1 is data access. Only one transaction
//            is in flight at a time. The sequence is: arbitrate in IDLE,
//            forward in GRANT, then route the read data back in WAIT_RD.
// Ports    : clk       - system clock; all logic uses the rising edge
//            reset_n   - asynchronous, active-low reset
//            p0, p1    - requesting ports (slave modport of sdram_arbiter_if)
//            mem       - link to the SDRAM controller (master modport)
//            dbg_state - current FSM state (0 IDLE, 1 GRANT, 2 WAIT_RD)
// Params   : ADDR_W, DATA_W - bus widths; these must match the interfaces
//            RR             - 1 selects round-robin, 0 gives port 0 fixed priority
// Revision : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int RR     = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sdram_arbiter_if.slave        p0,
  sdram_arbiter_if.slave        p1,
  sdram_arbiter_if.master       mem,
  output logic [1:0]            dbg_state
);

  localparam int BWE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;   // 0: port 0 owns the bus, 1: port 1
  logic   last_q,  last_d;    // port that completed the most recent transaction

  // Request fields of the granted port, selected by the registered grant.
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [BWE_W-1:0]  sel_bwe;
  logic              sel_we;
  logic              sel_req;

  always_comb begin
    if (grant_q) begin
      sel_addr = p1.addr;
      sel_data = p1.data;
      sel_bwe  = p1.bwe;
      sel_we   = p1.we;
      sel_req  = p1.req;
    end else begin
      sel_addr = p0.addr;
      sel_data = p0.data;
      sel_bwe  = p0.bwe;
      sel_we   = p0.we;
      sel_req  = p0.req;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;        // port 0 wins the first contested arbitration
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (p0.req || p1.req) begin
          state_d = ST_GRANT;
          if (p0.req && p1.req) begin
            grant_d = (RR != 0) ? ~last_q : 1'b0;
          end else begin
            grant_d = p1.req;
          end
        end
      end
      ST_GRANT: begin
        // A requester that drops its request before the ack aborts the
        // transaction. The fairness history is left untouched.
        if (!sel_req) begin
          state_d = ST_IDLE;
        end else if (mem.ack) begin
          if (sel_we) begin
            last_d  = grant_q;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_RD;
          end
        end
      end
      ST_WAIT_RD: begin
        if (mem.valid) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;   // unused encoding recovers to IDLE
    endcase
  end

  // --------------------------------------------------------------------------
  // Output routing
  // --------------------------------------------------------------------------
  always_comb begin
    mem.addr = '0;
    mem.data = '0;
    mem.bwe  = '0;
    mem.we   = 1'b0;
    mem.req  = 1'b0;
    p0.ack   = 1'b0;
    p1.ack   = 1'b0;
    p0.valid = 1'b0;
    p1.valid = 1'b0;
    p0.q     = '0;
    p1.q     = '0;
    case (state_q)
      ST_GRANT: begin
        mem.addr = sel_addr;
        mem.data = sel_data;
        mem.bwe  = sel_bwe;
        mem.we   = sel_we;
        // mem.req follows the live request, so an abort drops it in the
        // same cycle.
        mem.req  = sel_req;
        // The ack is gated by the request, so an aborting port cannot
        // receive one.
        p0.ack   = mem.ack & sel_req & ~grant_q;
        p1.ack   = mem.ack & sel_req &  grant_q;
      end
      ST_WAIT_RD: begin
        p0.valid = mem.valid & ~grant_q;
        p1.valid = mem.valid &  grant_q;
        p0.q     = mem.q;
        p1.q     = mem.q;
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_arbiter
// Purpose  : Self-checking bench for sdram_arbiter. A round-robin instance and
//            a fixed-priority instance share one set of stimulus; `sel` routes
//            the stimulus to one instance and the other instance sees idle
//            inputs. A transaction-level model predicts every output on
//            every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

  logic clk;
  logic rst_n;
  logic sel;                     // 0: round-robin DUT, 1: fixed-priority DUT

  // Stimulus, indexed by port.
  logic        s_req  [2];
  logic        s_we   [2];
  logic [23:0] s_addr [2];
  logic [31:0] s_data [2];
  logic [3:0]  s_bwe  [2];
  logic        s_mack;
  logic        s_mvalid;
  logic [31:0] s_mq;

  sdram_arbiter_if #(.ADDR_W(24), .DATA_W(32)) a_p0 ();
  sdram_arbiter_if #(.ADDR_W(24), .DATA_W(32)) a_p1 ();
  sdram_arbiter_if #(.ADDR_W(24), .DATA_W(32)) a_mem ();
  sdram_arbiter_if #(.ADDR_W(24), .DATA_W(32)) b_p0 ();
  sdram_arbiter_if #(.ADDR_W(24), .DATA_W(32)) b_p1 ();
  sdram_arbiter_if #(.ADDR_W(24), .DATA_W(32)) b_mem ();
  logic [1:0] dbg_a, dbg_b;

  assign a_p0.req  = !sel & s_req[0];
  assign a_p0.we   = !sel & s_we[0];
  assign a_p0.addr = sel ? '0 : s_addr[0];
  assign a_p0.data = sel ? '0 : s_data[0];
  assign a_p0.bwe  = sel ? '0 : s_bwe[0];
  assign a_p1.req  = !sel & s_req[1];
  assign a_p1.we   = !sel & s_we[1];
  assign a_p1.addr = sel ? '0 : s_addr[1];
  assign a_p1.data = sel ? '0 : s_data[1];
  assign a_p1.bwe  = sel ? '0 : s_bwe[1];
  assign a_mem.ack   = !sel & s_mack;
  assign a_mem.valid = !sel & s_mvalid;
  assign a_mem.q     = s_mq;

  assign b_p0.req  = sel & s_req[0];
  assign b_p0.we   = sel & s_we[0];
  assign b_p0.addr = sel ? s_addr[0] : '0;
  assign b_p0.data = sel ? s_data[0] : '0;
  assign b_p0.bwe  = sel ? s_bwe[0] : '0;
  assign b_p1.req  = sel & s_req[1];
  assign b_p1.we   = sel & s_we[1];
  assign b_p1.addr = sel ? s_addr[1] : '0;
  assign b_p1.data = sel ? s_data[1] : '0;
  assign b_p1.bwe  = sel ? s_bwe[1] : '0;
  assign b_mem.ack   = sel & s_mack;
  assign b_mem.valid = sel & s_mvalid;
  assign b_mem.q     = s_mq;

  sdram_arbiter #(.ADDR_W(24), .DATA_W(32), .RR(1)) dut_rr (
    .clk(clk), .reset_n(rst_n), .p0(a_p0), .p1(a_p1), .mem(a_mem), .dbg_state(dbg_a)
  );
  sdram_arbiter #(.ADDR_W(24), .DATA_W(32), .RR(0)) dut_fx (
    .clk(clk), .reset_n(rst_n), .p0(b_p0), .p1(b_p1), .mem(b_mem), .dbg_state(dbg_b)
  );

  // Outputs of the currently selected instance.
  logic        o_ack0, o_ack1, o_val0, o_val1, o_mreq, o_mwe;
  logic [31:0] o_q0, o_q1, o_mdata;
  logic [23:0] o_maddr;
  logic [3:0]  o_mbwe;
  logic [1:0]  o_dbg;
  assign o_ack0  = sel ? b_p0.ack   : a_p0.ack;
  assign o_ack1  = sel ? b_p1.ack   : a_p1.ack;
  assign o_val0  = sel ? b_p0.valid : a_p0.valid;
  assign o_val1  = sel ? b_p1.valid : a_p1.valid;
  assign o_q0    = sel ? b_p0.q     : a_p0.q;
  assign o_q1    = sel ? b_p1.q     : a_p1.q;
  assign o_mreq  = sel ? b_mem.req  : a_mem.req;
  assign o_mwe   = sel ? b_mem.we   : a_mem.we;
  assign o_maddr = sel ? b_mem.addr : a_mem.addr;
  assign o_mdata = sel ? b_mem.data : a_mem.data;
  assign o_mbwe  = sel ? b_mem.bwe  : a_mem.bwe;
  assign o_dbg   = sel ? dbg_b      : dbg_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Transaction model: which port owns the bus, whether it awaits read data,
  // and who finished last. Every granted port is logged.
  // --------------------------------------------------------------------------
  int m_owner;                   // -1 when no transaction is open
  bit m_read;
  int m_last;
  int m_grants[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_read  = 1'b0;
      m_last  = 1;
    end else if (m_owner < 0) begin
      if (s_req[0] && s_req[1]) m_owner = (sel == 1'b0) ? 1 - m_last : 0;
      else if (s_req[0])        m_owner = 0;
      else if (s_req[1])        m_owner = 1;
      if (m_owner >= 0) m_grants.push_back(m_owner);
    end else if (!m_read) begin
      if (!s_req[m_owner]) begin
        m_owner = -1;
      end else if (s_mack) begin
        if (s_we[m_owner]) begin
          m_last  = m_owner;
          m_owner = -1;
        end else begin
          m_read = 1'b1;
        end
      end
    end else if (s_mvalid) begin
      m_last  = m_owner;
      m_owner = -1;
      m_read  = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Checking. All comparisons are made from the single stimulus process.
  // --------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int cnt_ack[2]   = '{0, 0};
  int cnt_valid[2] = '{0, 0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic        e_mreq, e_mwe;
    logic [23:0] e_maddr;
    logic [31:0] e_mdata;
    logic [3:0]  e_mbwe;
    logic        e_ack[2];
    logic        e_val[2];
    logic [1:0]  e_dbg;
    e_mreq = 0; e_mwe = 0; e_maddr = '0; e_mdata = '0; e_mbwe = '0;
    e_ack = '{1'b0, 1'b0};
    e_val = '{1'b0, 1'b0};
    e_dbg = 2'd0;
    if (m_owner >= 0 && !m_read) begin
      e_dbg   = 2'd1;
      e_mreq  = s_req[m_owner];
      e_mwe   = s_we[m_owner];
      e_maddr = s_addr[m_owner];
      e_mdata = s_data[m_owner];
      e_mbwe  = s_bwe[m_owner];
      e_ack[m_owner] = s_mack & s_req[m_owner];
    end else if (m_owner >= 0) begin
      e_dbg = 2'd2;
      e_val[m_owner] = s_mvalid;
    end
    chk("cyc_dbg_state", o_dbg, e_dbg);
    chk("cyc_mem_req", o_mreq, e_mreq);
    chk("cyc_mem_bus", {o_mwe, o_mbwe, o_maddr, o_mdata}, {e_mwe, e_mbwe, e_maddr, e_mdata});
    chk("cyc_acks", {o_ack1, o_ack0}, {e_ack[1], e_ack[0]});
    chk("cyc_valids", {o_val1, o_val0}, {e_val[1], e_val[0]});
    if (m_read) chk("cyc_q", {o_q1, o_q0}, {s_mq, s_mq});
    if (o_ack0) cnt_ack[0]++;
    if (o_ack1) cnt_ack[1]++;
    if (o_val0) cnt_valid[0]++;
    if (o_val1) cnt_valid[1]++;
  endtask

  // Checks the cycle at the negedge, then returns 1 time unit after the next
  // rising edge, where new inputs may be driven.
  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  // Simple controller: it acks any request it sees and returns data in WAIT_RD.
  task automatic auto_run(input int n);
    repeat (n) begin
      #1;
      s_mack   = o_mreq;
      s_mvalid = (o_dbg == 2'd2);
      s_mq     = $urandom;
      step();
    end
    s_mack   = 1'b0;
    s_mvalid = 1'b0;
  endtask

  int g0, a0, a1, v0, v1;

  initial begin
    sel = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_req[i] = 0; s_we[i] = 0; s_addr[i] = '0; s_data[i] = '0; s_bwe[i] = '0;
    end
    s_mack = 0; s_mvalid = 0; s_mq = '0;
    step(); step();
    chk("reset_outputs", {o_dbg, o_mreq, o_ack0, o_ack1, o_val0, o_val1}, 0);
    rst_n = 1'b1;
    step();
    chk("after_release_outputs", {o_dbg, o_mreq, o_maddr, o_q0, o_q1}, 0);

    // 1: p0 write, controller acks after 3 cycles
    a0 = cnt_ack[0]; a1 = cnt_ack[1];
    s_req[0] = 1; s_we[0] = 1; s_addr[0] = 24'h000000; s_data[0] = 32'h0; s_bwe[0] = 4'hF;
    #1 chk("t1_mem_req_same_cycle", o_mreq, 0);
    step();
    chk("t1_mem_req_next_cycle", o_mreq, 1);
    step(); step();
    s_mack = 1;
    #1 chk("t1_p0_ack", {o_ack1, o_ack0}, 2'b01);
    step();
    s_mack = 0; s_req[0] = 0; s_we[0] = 0;
    #1 chk("t1_back_to_idle", o_dbg, 0);
    step();
    chk("t1_ack_pulses", {cnt_ack[0] - a0, cnt_ack[1] - a1}, {32'd1, 32'd0});

    // mem_valid in IDLE is not routed
    v0 = cnt_valid[0]; v1 = cnt_valid[1];
    s_mvalid = 1; s_mq = 32'h12345678;
    step();
    s_mvalid = 0;
    step();
    chk("idle_valid_ignored", {cnt_valid[0] - v0, cnt_valid[1] - v1}, 0);

    // 2: p1 read returning 0xFEEDBEEF
    s_req[1] = 1; s_we[1] = 0; s_addr[1] = 24'h40CAFE; s_data[1] = 32'h55; s_bwe[1] = 4'hF;
    step();
    chk("t2_mem_addr", o_maddr, 24'h40CAFE);
    s_mack = 1;
    step();
    s_mack = 0; s_req[1] = 0;
    step();
    s_mvalid = 1; s_mq = 32'hFEEDBEEF;
    #1 chk("t2_p1_valid", {o_val1, o_val0}, 2'b10);
    chk("t2_p1_q", o_q1, 32'hFEEDBEEF);
    step();
    s_mvalid = 0;
    #1 chk("t2_idle", o_dbg, 0);
    step();

    // 3: round robin, both ports read continuously
    g0 = m_grants.size(); v0 = cnt_valid[0]; v1 = cnt_valid[1];
    s_req[0] = 1; s_we[0] = 0; s_addr[0] = 24'h000100;
    s_req[1] = 1; s_we[1] = 0; s_addr[1] = 24'h000200;
    auto_run(12);
    s_req[0] = 0; s_req[1] = 0;
    step();
    chk("t3_grant_count", m_grants.size() - g0, 4);
    chk("t3_grant_order", {m_grants[g0][3:0], m_grants[g0+1][3:0], m_grants[g0+2][3:0], m_grants[g0+3][3:0]}, 16'h0101);
    chk("t3_valid_per_port", {cnt_valid[0] - v0, cnt_valid[1] - v1}, {32'd2, 32'd2});

    // 5: reset asserted in WAIT_RD, then late mem_valid
    s_req[0] = 1; s_we[0] = 0; s_addr[0] = 24'h000007;
    step();
    s_mack = 1;
    step();
    s_mack = 0; s_req[0] = 0;
    #1 chk("t5_in_wait_rd", o_dbg, 2);
    v0 = cnt_valid[0];
    rst_n = 0;
    #1 chk("t5_reset_outputs", {o_dbg, o_mreq, o_ack0, o_ack1, o_val0, o_val1}, 0);
    step();
    rst_n = 1;
    step();
    s_mvalid = 1; s_mq = 32'hDEADDEAD;
    step();
    s_mvalid = 0;
    step();
    chk("t5_no_valid", cnt_valid[0] - v0, 0);

    // 6: p1 drops request in GRANT before mem_ack
    a1 = cnt_ack[1];
    s_req[1] = 1; s_we[1] = 1; s_addr[1] = 24'h000123; s_data[1] = 32'hA5A5A5A5;
    step();
    chk("t6_mem_req_up", o_mreq, 1);
    s_req[1] = 0;
    #1 chk("t6_mem_req_drops", o_mreq, 0);
    step();
    chk("t6_idle_next", o_dbg, 0);
    step();
    chk("t6_no_ack", cnt_ack[1] - a1, 0);

    // 4: fixed priority instance, both ports request continuously
    rst_n = 0; sel = 1;
    step();
    rst_n = 1;
    step();
    g0 = m_grants.size(); v1 = cnt_valid[1];
    s_req[0] = 1; s_we[0] = 0; s_addr[0] = 24'h000300;
    s_req[1] = 1; s_we[1] = 0; s_addr[1] = 24'h000400;
    auto_run(12);
    chk("t4_p1_starved", cnt_valid[1] - v1, 0);
    chk("t4_grants_p0", {m_grants.size() - g0, m_grants[g0][3:0], m_grants[g0+3][3:0]}, {32'd4, 8'h00});
    s_req[0] = 0;
    auto_run(6);
    s_req[1] = 0;
    step();
    chk("t4_p1_served", cnt_valid[1] - v1, 2);
    chk("t4_p1_grant", m_grants[g0+4], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
